// File: rtl/button_debounce_bank.sv
// Bank of independent push-button conditioners: synchroniser, stability-counter debounce, press/release/auto-repeat pulses.
// BTN and its pulses follow a raw step by SYNC_STAGES-1+STABLE_COUNT cycles; no backpressure, pulses are single-cycle.
module button_debounce_bank #(
  parameter int CHANNELS     = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int CNT_WIDTH    = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RATE_LAST   = CNT_WIDTH'(REPEAT_RATE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   btn_q;
    logic                   press_q;
    logic                   release_q;
    logic                   repeat_q;
    logic                   first_q;
    logic [CNT_WIDTH-1:0]   dc_q;
    logic [CNT_WIDTH-1:0]   rc_q;
    logic [CNT_WIDTH-1:0]   rc_last;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rc_last = first_q ? DELAY_LAST : RATE_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
      end
    end

    // Any cycle where s agrees with the debounced level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dc_q      <= '0;
        btn_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (s == btn_q) begin
          dc_q <= '0;
        end else if (dc_q == STABLE_LAST) begin
          dc_q      <= '0;
          btn_q     <= s;
          press_q   <= s;
          release_q <= ~s;
        end else begin
          dc_q <= dc_q + CNT_ONE;
        end
      end
    end

    // The PRESS cycle itself counts as the first held cycle, so the first
    // REPEAT lands exactly REPEAT_DELAY cycles after PRESS.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rc_q     <= '0;
        first_q  <= 1'b1;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        if (!btn_q || !repeat_en[i]) begin
          rc_q    <= '0;
          first_q <= 1'b1;
        end else if (rc_q == rc_last) begin
          rc_q     <= '0;
          first_q  <= 1'b0;
          repeat_q <= 1'b1;
        end else begin
          rc_q <= rc_q + CNT_ONE;
        end
      end
    end

    assign btn[i]         = btn_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank with STABLE_COUNT=4, REPEAT_DELAY=6, REPEAT_RATE=3.
// Inputs are driven 1 time unit after a rising edge and outputs sampled at the same point.
module tb_button_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] repeat_en;
  logic [1:0] btn;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_repeat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debounce_bank #(
    .CHANNELS    (2),
    .SYNC_STAGES (2),
    .STABLE_COUNT(4),
    .REPEAT_DELAY(6),
    .REPEAT_RATE (3),
    .CNT_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .btn        (btn),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driving after edge e: edge e+1 samples, edge e+6 (iteration 6) shows the new BTN.
  task automatic test_reset();
    logic [1:0] exp_press;
    logic [1:0] exp_btn;
    logic [1:0] exp_rel;
    rst_n   = 1'b0;
    btn_raw = 2'b11;
    repeat (3) tick();
    checks++;
    if ({btn, btn_press, btn_release, btn_repeat} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", {btn, btn_press, btn_release, btn_repeat}, 8'h00);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_press = (n == 6) ? 2'b11 : 2'b00;
      exp_btn   = (n >= 6) ? 2'b11 : 2'b00;
      checks++;
      if (btn_press !== exp_press || btn !== exp_btn) begin
        errors++;
        $display("FAIL reset_release_press n=%0d: got press=%b btn=%b required press=%b btn=%b",
                 n, btn_press, btn, exp_press, exp_btn);
      end
    end
    btn_raw = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_rel = (n == 6) ? 2'b11 : 2'b00;
      checks++;
      if (btn_release !== exp_rel) begin
        errors++;
        $display("FAIL reset_flush_release n=%0d: got %b required %b", n, btn_release, exp_rel);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [1:0] exp_btn;
    logic [1:0] exp_pulse;
    btn_raw = 2'b01;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_btn   = (n >= 6) ? 2'b01 : 2'b00;
      exp_pulse = (n == 6) ? 2'b01 : 2'b00;
      checks++;
      if (btn !== exp_btn || btn_press !== exp_pulse || btn_release !== 2'b00) begin
        errors++;
        $display("FAIL clean_press n=%0d: got btn=%b press=%b rel=%b required btn=%b press=%b rel=00",
                 n, btn, btn_press, btn_release, exp_btn, exp_pulse);
      end
    end
    btn_raw = 2'b00;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_btn   = (n >= 6) ? 2'b00 : 2'b01;
      exp_pulse = (n == 6) ? 2'b01 : 2'b00;
      checks++;
      if (btn !== exp_btn || btn_release !== exp_pulse || btn_press !== 2'b00) begin
        errors++;
        $display("FAIL clean_release n=%0d: got btn=%b rel=%b press=%b required btn=%b rel=%b press=00",
                 n, btn, btn_release, btn_press, exp_btn, exp_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pattern;
    int         presses;
    pattern = 8'b0111_0111;  // applied LSB first: 1,1,1,0,1,1,1,0
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 8; b++) begin
        btn_raw = {1'b0, pattern[b]};
        tick();
        checks++;
        if (btn !== 2'b00 || btn_press !== 2'b00) begin
          errors++;
          $display("FAIL bounce_reject r=%0d b=%0d: got btn=%b press=%b required btn=00 press=00",
                   r, b, btn, btn_press);
        end
      end
    end
    btn_raw = 2'b01;
    presses = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (btn_press[0]) presses++;
    end
    checks++;
    if (presses != 1 || btn !== 2'b01) begin
      errors++;
      $display("FAIL bounce_settle: got presses=%0d btn=%b required presses=1 btn=01", presses, btn);
    end
    btn_raw = 2'b00;
    repeat (8) tick();
    checks++;
    if (btn !== 2'b00) begin
      errors++;
      $display("FAIL bounce_flush: got btn=%b required 00", btn);
    end
  endtask

  // m counts edges after the PRESS edge; REPEAT_EN is sampled low only at edge PRESS+11.
  task automatic test_auto_repeat();
    logic [1:0] exp_rep;
    repeat_en = 2'b01;
    btn_raw   = 2'b01;
    repeat (6) tick();
    checks++;
    if (btn_press !== 2'b01) begin
      errors++;
      $display("FAIL repeat_press: got %b required 01", btn_press);
    end
    for (int m = 1; m <= 19; m++) begin
      if (m == 11) repeat_en = 2'b00;
      if (m == 12) repeat_en = 2'b01;
      tick();
      exp_rep = (m == 6 || m == 9 || m == 17) ? 2'b01 : 2'b00;
      checks++;
      if (btn_repeat !== exp_rep || btn_press !== 2'b00) begin
        errors++;
        $display("FAIL auto_repeat m=%0d: got rep=%b press=%b required rep=%b press=00",
                 m, btn_repeat, btn_press, exp_rep);
      end
    end
    btn_raw   = 2'b00;
    repeat_en = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      tick();
      checks++;
      if (btn_repeat !== 2'b00 || btn_release !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL repeat_release n=%0d: got rep=%b rel=%b required rep=00 rel=%b",
                 n, btn_repeat, btn_release, (n == 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_pulse;
    logic [1:0] exp_btn;
    btn_raw = 2'b11;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_pulse = (n == 6) ? 2'b11 : 2'b00;
      checks++;
      if (btn_press !== exp_pulse) begin
        errors++;
        $display("FAIL simul_press n=%0d: got %b required %b", n, btn_press, exp_pulse);
      end
    end
    btn_raw = 2'b01;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_pulse = (n == 6) ? 2'b10 : 2'b00;
      exp_btn   = (n >= 6) ? 2'b01 : 2'b11;
      checks++;
      if (btn_release !== exp_pulse || btn !== exp_btn || btn_press !== 2'b00) begin
        errors++;
        $display("FAIL simul_release_ch1 n=%0d: got rel=%b btn=%b press=%b required rel=%b btn=%b press=00",
                 n, btn_release, btn, btn_press, exp_pulse, exp_btn);
      end
    end
    btn_raw = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_pulse = (n == 6) ? 2'b01 : 2'b00;
      checks++;
      if (btn_release !== exp_pulse) begin
        errors++;
        $display("FAIL simul_release_ch0 n=%0d: got %b required %b", n, btn_release, exp_pulse);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_pulse;
    btn_raw = 2'b10;
    repeat (7) tick();
    checks++;
    if (btn !== 2'b10) begin
      errors++;
      $display("FAIL midreset_setup: got btn=%b required 10", btn);
    end
    btn_raw = 2'b11;
    repeat (4) tick();  // ch0 debounce count now at 2
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn, btn_press, btn_release, btn_repeat} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_async: got %b required %b", {btn, btn_press, btn_release, btn_repeat}, 8'h00);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_pulse = (n == 6) ? 2'b11 : 2'b00;
      checks++;
      if (btn_press !== exp_pulse) begin
        errors++;
        $display("FAIL midreset_press n=%0d: got %b required %b", n, btn_press, exp_pulse);
      end
    end
    btn_raw = 2'b00;
    repeat (8) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_raw   = 2'b00;
    repeat_en = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
